// File: rtl/vector_packer.sv
// Packs variable-length input beats (1..N lanes, length per chain from firmware) into dense
// N-lane output vectors. Define VECTOR_PACKER_EOF_FLUSH_EN to enable end-of-frame flushing.
module vector_packer #(
    parameter int unsigned N = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_CHAINS = 4,
    parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE = {MAX_CHAINS{8'(N)}},
    localparam int unsigned CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int unsigned COUNT_W = $clog2(N + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tracing,
    input  logic                             valid_in,
    input  logic                             eof_in,
    input  logic [CHAIN_W-1:0]               chainId_in,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic                             ready_out,
    input  logic                             ready_in,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic [COUNT_W-1:0]               count_out,
    output logic                             valid_out
);

    localparam int unsigned TOT_W = $clog2(2 * N);
    localparam int unsigned IDX_W = $clog2(2 * N - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic {StRun, StFlush} state_e;
    typedef enum logic {CfgIdle, CfgAddr} cfg_state_e;

    state_e                        state_q, state_d;
    cfg_state_e                    cfg_q, cfg_d;
    logic [7:0]                    idx_q, idx_d;
    logic                          fw_we;
    logic [7:0]                    fw_q [MAX_CHAINS];
    word_t                         res_q [N-1];
    word_t                         res_d [N-1];
    logic [COUNT_W-1:0]            fill_q, fill_d;
    logic [N-1:0][DATA_WIDTH-1:0]  out_q, out_d;
    logic [COUNT_W-1:0]            cnt_q, cnt_d;
    logic                          vld_q, vld_d;

    logic [7:0]                    fw_sel;
    logic [COUNT_W-1:0]            len;
    logic [TOT_W-1:0]              tot;
    logic                          out_free;
    logic                          accept;
    word_t                         cat [2*N-1];
    word_t                         tail [N-1];
    logic [N-1:0][DATA_WIDTH-1:0]  head, flush_vec;

`ifndef VECTOR_PACKER_EOF_FLUSH_EN
    logic unused_eof;
    assign unused_eof = eof_in;
`endif

    assign fw_sel    = fw_q[chainId_in];
    assign len       = (fw_sel > 8'(N)) ? COUNT_W'(N) : COUNT_W'(fw_sel);
    assign tot       = TOT_W'(fill_q) + TOT_W'(len);
    assign out_free  = !vld_q || ready_in;
    assign ready_out = (state_q == StRun) && out_free;
    assign accept    = valid_in && ready_out && tracing;

    assign vector_out = out_q;
    assign count_out  = cnt_q;
    assign valid_out  = vld_q;

    // Residual followed by the meaningful input lanes, zero beyond fill + len.
    always_comb begin
        for (int k = 0; k < 2 * N - 1; k++) cat[k] = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (COUNT_W'(k) < fill_q) cat[k] = res_q[k];
        end
        for (int j = 0; j < N; j++) begin
            if (COUNT_W'(j) < len) cat[IDX_W'(fill_q) + IDX_W'(j)] = vector_in[j];
        end
        for (int i = 0; i < N; i++) head[i] = cat[i];
        for (int i = 0; i < N - 1; i++) tail[i] = cat[N+i];
        flush_vec = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (COUNT_W'(i) < fill_q) flush_vec[i] = res_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        fill_d  = fill_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        if (vld_q && ready_in) vld_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (accept) begin
`ifdef VECTOR_PACKER_EOF_FLUSH_EN
                    if (eof_in && (tot <= TOT_W'(N))) begin
                        if (tot != '0) begin
                            out_d = head;
                            cnt_d = COUNT_W'(tot);
                            vld_d = 1'b1;
                        end
                        fill_d = '0;
                    end else if (tot >= TOT_W'(N)) begin
                        out_d  = head;
                        cnt_d  = COUNT_W'(N);
                        vld_d  = 1'b1;
                        res_d  = tail;
                        fill_d = COUNT_W'(tot - TOT_W'(N));
                        if (eof_in) state_d = StFlush;
                    end else begin
                        for (int k = 0; k < N - 1; k++) res_d[k] = cat[k];
                        fill_d = COUNT_W'(tot);
                    end
`else
                    if (tot >= TOT_W'(N)) begin
                        out_d  = head;
                        cnt_d  = COUNT_W'(N);
                        vld_d  = 1'b1;
                        res_d  = tail;
                        fill_d = COUNT_W'(tot - TOT_W'(N));
                    end else begin
                        for (int k = 0; k < N - 1; k++) res_d[k] = cat[k];
                        fill_d = COUNT_W'(tot);
                    end
`endif
                end
            end
            StFlush: begin
                if (out_free) begin
                    out_d   = flush_vec;
                    cnt_d   = fill_q;
                    vld_d   = 1'b1;
                    fill_d  = '0;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Config writes take an index cycle then a data cycle; tracing aborts the sequence.
    always_comb begin
        cfg_d = cfg_q;
        idx_d = idx_q;
        fw_we = 1'b0;
        if (tracing) begin
            cfg_d = CfgIdle;
        end else begin
            unique case (cfg_q)
                CfgIdle: begin
                    if (configId == PERSONAL_CONFIG_ID) begin
                        idx_d = configData;
                        cfg_d = CfgAddr;
                    end
                end
                CfgAddr: begin
                    if (configId == PERSONAL_CONFIG_ID) begin
                        fw_we = (idx_q < 8'(MAX_CHAINS));
                        cfg_d = CfgIdle;
                    end
                end
                default: cfg_d = CfgIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            res_q   <= '{default: '0};
            fill_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= CfgIdle;
            idx_q <= '0;
            for (int i = 0; i < MAX_CHAINS; i++) fw_q[i] <= INITIAL_FIRMWARE[i];
        end else begin
            cfg_q <= cfg_d;
            idx_q <= idx_d;
            if (fw_we) fw_q[idx_q[CHAIN_W-1:0]] <= configData;
        end
    end

endmodule
